mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester cache-line memory arbiter, round-robin on contention; read latency grant->first rd_valid = 2 + WAIT cycles.
// Backpressure: requesters hold req_valid until grant and advance wdata on wbeat_ack; memory paces reads via mem_resp.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16,
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        grant,
  output logic [1:0]        wbeat_ack,
  output logic [1:0]        rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;
  localparam int         BW            = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CMD, WAIT, RDATA, DONE} state_t;

  state_t            state, state_n;
  logic              id, id_n, op_wr, op_wr_n, rr, rr_n;
  logic [BW-1:0]     beat_cnt, beat_cnt_n;
  logic [7:0]        wait_cnt, wait_cnt_n;
  logic [1:0]        grant_n, wbeat_ack_n, rd_valid_n, done_n, err_n, mem_cmd_n;
  logic [DATA_W-1:0] rd_data_n, mem_wdata_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic              sel, take_beat;
  logic [1:0]        sel_oh, id_oh;
  logic [DATA_W-1:0] cur_wdata;

  assign sel       = (&req_valid) ? rr : req_valid[1];
  assign sel_oh    = {sel, ~sel};
  assign id_oh     = {id, ~id};
  assign cur_wdata = id ? req_wdata1 : req_wdata0;
  assign take_beat = mem_resp && !op_wr && (state == WAIT || state == RDATA);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      id        <= 1'b0;
      op_wr     <= 1'b0;
      rr        <= 1'b0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      grant     <= '0;
      wbeat_ack <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      done      <= '0;
      err       <= '0;
      mem_cmd   <= C2_NOP;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      id        <= id_n;
      op_wr     <= op_wr_n;
      rr        <= rr_n;
      beat_cnt  <= beat_cnt_n;
      wait_cnt  <= wait_cnt_n;
      grant     <= grant_n;
      wbeat_ack <= wbeat_ack_n;
      rd_valid  <= rd_valid_n;
      rd_data   <= rd_data_n;
      done      <= done_n;
      err       <= err_n;
      mem_cmd   <= mem_cmd_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    id_n        = id;
    op_wr_n     = op_wr;
    rr_n        = rr;
    beat_cnt_n  = beat_cnt;
    wait_cnt_n  = wait_cnt;
    grant_n     = '0;
    wbeat_ack_n = '0;
    rd_valid_n  = '0;
    rd_data_n   = rd_data;
    done_n      = '0;
    err_n       = '0;
    mem_cmd_n   = C2_NOP;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;

    case (state)
      IDLE: begin
        if (|req_valid) begin
          id_n       = sel;
          op_wr_n    = req_write[sel];
          mem_addr_n = sel ? req_addr1 : req_addr0;
          grant_n    = sel_oh;
          beat_cnt_n = '0;
          wait_cnt_n = '0;
          state_n    = CMD;
          // Write beat 0 goes out together with the grant.
          if (req_write[sel]) begin
            mem_cmd_n   = C2_WRITE_LINE;
            mem_wdata_n = sel ? req_wdata1 : req_wdata0;
            wbeat_ack_n = sel_oh;
          end else begin
            mem_cmd_n = C2_READ_LINE;
          end
        end
      end
      CMD: begin
        if (!op_wr || beat_cnt == LAST_BEAT) begin
          beat_cnt_n = '0;
          state_n    = WAIT;
        end else begin
          beat_cnt_n  = beat_cnt + BW'(1);
          mem_cmd_n   = C2_WRITE_LINE;
          mem_wdata_n = cur_wdata;
          wbeat_ack_n = id_oh;
        end
      end
      WAIT: begin
        if (mem_resp) begin
          if (op_wr) begin
            done_n  = id_oh;
            state_n = DONE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          err_n      = id_oh;
          done_n     = id_oh;
          rr_n       = ~id;
          wait_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      RDATA: ;
      DONE: begin
        rr_n       = ~id;
        wait_cnt_n = '0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Read beats share one path whether the first arrives in WAIT or later ones in RDATA.
    if (take_beat) begin
      rd_valid_n = id_oh;
      rd_data_n  = mem_rdata;
      if (beat_cnt == LAST_BEAT) begin
        beat_cnt_n = '0;
        done_n     = id_oh;
        state_n    = DONE;
      end else begin
        beat_cnt_n = beat_cnt + BW'(1);
        state_n    = RDATA;
      end
    end
  end

endmodule
